// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: writeback-select encodings,
// occupancy states and the packed payload layout (default widths).
package ex_mem_pkg;

    localparam int WDSEL_W = 2;

    localparam logic [WDSEL_W-1:0] WD_ALU  = 2'd0;
    localparam logic [WDSEL_W-1:0] WD_DRAM = 2'd1;
    localparam logic [WDSEL_W-1:0] WD_PC4  = 2'd2;
    localparam logic [WDSEL_W-1:0] WD_IMM  = 2'd3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Field order matches the concatenation used in ex_mem_stage (MSB first).
    typedef struct packed {
        logic [WDSEL_W-1:0] wd_sel;
        logic               rf_we;
        logic               dram_we;
        logic [4:0]         wR;
        logic [31:0]        wD;
        logic [31:0]        alu_c;
        logic [31:0]        rD2;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register over a packed payload. With EX_MEM_SKID_EN
// defined it becomes a two-entry skid buffer with a registered in_ready.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_t         state_reg, state_next;
    logic [W-1:0] m_reg, m_next;
    logic         alive_reg;
    logic         in_fire;

`ifdef EX_MEM_SKID_EN
    logic [W-1:0] s_reg, s_next;
    // in_ready depends only on registered state, so MEM stall never reaches EX combinationally.
    assign in_ready = alive_reg & (state_reg != OCC_TWO);
`else
    assign in_ready = alive_reg & (out_ready | ~out_valid);
`endif

    assign out_valid = (state_reg != OCC_EMPTY);
    assign out_data  = m_reg;
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
`ifdef EX_MEM_SKID_EN
        s_next     = s_reg;
`endif
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
`ifdef EX_MEM_SKID_EN
            case (state_reg)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        state_next = OCC_ONE;
                        m_next     = in_data;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_ready) begin
                        m_next = in_data;
                    end else if (in_fire) begin
                        state_next = OCC_TWO;
                        s_next     = in_data;
                    end else if (out_ready) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_ready) begin
                        state_next = OCC_ONE;
                        m_next     = s_reg;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
`else
            if (in_fire) begin
                state_next = OCC_ONE;
                m_next     = in_data;
            end else if (out_valid && out_ready) begin
                state_next = OCC_EMPTY;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= OCC_EMPTY;
            m_reg     <= '0;
            alive_reg <= 1'b0;
`ifdef EX_MEM_SKID_EN
            s_reg     <= '0;
`endif
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            alive_reg <= 1'b1;
`ifdef EX_MEM_SKID_EN
            s_reg     <= s_next;
`endif
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Elastic EX->MEM stage register for the RV32 pipeline; optional skid buffer via
// EX_MEM_SKID_EN. Write enables are gated by out_valid so bubbles never write.
module ex_mem_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int WDSEL_W = ex_mem_pkg::WDSEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WDSEL_W-1:0] wd_sel_i,
    input  logic               rf_we_i,
    input  logic               dram_we_i,
    input  logic [REG_AW-1:0]  wR_i,
    input  logic [XLEN-1:0]    wD_i,
    input  logic [XLEN-1:0]    alu_c_i,
    input  logic [XLEN-1:0]    rD2_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WDSEL_W-1:0] wd_sel_o,
    output logic               rf_we_o,
    output logic               dram_we_o,
    output logic [REG_AW-1:0]  wR_o,
    output logic [XLEN-1:0]    wD_o,
    output logic [XLEN-1:0]    alu_c_o,
    output logic [XLEN-1:0]    rD2_o
);

    localparam int PAY_W = WDSEL_W + 2 + REG_AW + 3 * XLEN;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;
    logic             m_rf_we;
    logic             m_dram_we;

    assign in_pay = {wd_sel_i, rf_we_i, dram_we_i, wR_i, wD_i, alu_c_i, rD2_i};

    pipe_skid_buf #(
        .W(PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {wd_sel_o, m_rf_we, m_dram_we, wR_o, wD_o, alu_c_o, rD2_o} = out_pay;

    // Stale payload survives a flush, so the enables must be qualified by valid.
    assign rf_we_o   = m_rf_we & out_valid;
    assign dram_we_o = m_dram_we & out_valid;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; skid-specific expectations
// follow EX_MEM_SKID_EN.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wd_sel_i;
    logic        rf_we_i;
    logic        dram_we_i;
    logic [4:0]  wR_i;
    logic [31:0] wD_i;
    logic [31:0] alu_c_i;
    logic [31:0] rD2_i;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  wd_sel_o;
    logic        rf_we_o;
    logic        dram_we_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;
    logic [31:0] alu_c_o;
    logic [31:0] rD2_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wd_sel_i  (wd_sel_i),
        .rf_we_i   (rf_we_i),
        .dram_we_i (dram_we_i),
        .wR_i      (wR_i),
        .wD_i      (wD_i),
        .alu_c_i   (alu_c_i),
        .rD2_i     (rD2_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wd_sel_o  (wd_sel_o),
        .rf_we_o   (rf_we_o),
        .dram_we_o (dram_we_o),
        .wR_o      (wR_o),
        .wD_o      (wD_o),
        .alu_c_o   (alu_c_o),
        .rD2_o     (rD2_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wr, input logic [31:0] alu,
                         input logic rf, input logic dw);
        in_valid  = v;
        wR_i      = wr;
        alu_c_i   = alu;
        wD_i      = alu + 32'd4;
        rD2_i     = alu ^ 32'h5555_0000;
        rf_we_i   = rf;
        dram_we_i = dw;
        wd_sel_i  = 2'd2;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 5'd9, 32'hDEAD, 1'b1, 1'b1);
        wd_sel_i  = 2'd3;

        // Reset held three cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("rst_alu_c_o", alu_c_o, 32'd0);
        check("rst_wR_o", {27'd0, wR_o}, 32'd0);
        check("rst_wd_sel_o", {30'd0, wd_sel_o}, 32'd0);
        check("rst_rf_we_o", {31'd0, rf_we_o}, 32'd0);
        check("rst_dram_we_o", {31'd0, dram_we_o}, 32'd0);

        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back streaming.
        drive(1'b1, 5'd5, 32'h100, 1'b1, 1'b0);
        tick();
        check("s1_valid", {31'd0, out_valid}, 32'd1);
        check("s1_wR", {27'd0, wR_o}, 32'd5);
        check("s1_alu", alu_c_o, 32'h100);
        check("s1_wD", wD_o, 32'h104);
        check("s1_rf_we", {31'd0, rf_we_o}, 32'd1);
        drive(1'b1, 5'd6, 32'h104, 1'b1, 1'b0);
        tick();
        check("s2_valid", {31'd0, out_valid}, 32'd1);
        check("s2_wR", {27'd0, wR_o}, 32'd6);
        check("s2_alu", alu_c_o, 32'h104);
        check("s2_rD2", rD2_o, 32'h5555_0104);
        check("s2_wd_sel", {30'd0, wd_sel_o}, 32'd2);

        // Bubbles with rf_we_i asserted must never write.
        drive(1'b0, 5'd3, 32'h300, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bub_valid", {31'd0, out_valid}, 32'd0);
            check("bub_rf_we", {31'd0, rf_we_o}, 32'd0);
        end

        // Back-pressure.
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 32'hA0, 1'b0, 1'b1);
        tick();
        check("bp_a_valid", {31'd0, out_valid}, 32'd1);
        check("bp_a_wR", {27'd0, wR_o}, 32'd7);
        drive(1'b1, 5'd8, 32'hB0, 1'b0, 1'b1);
        #1;
`ifdef EX_MEM_SKID_EN
        check("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_two_hold_wR", {27'd0, wR_o}, 32'd7);
        tick();
        check("bp_two_hold2", alu_c_o, 32'hA0);
        check("bp_two_in_ready2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_drain_b_wR", {27'd0, wR_o}, 32'd8);
        check("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_drain_empty", {31'd0, out_valid}, 32'd0);

        // Refill to TWO, then flush alongside a new input.
        out_ready = 1'b0;
        drive(1'b1, 5'd10, 32'hC0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd11, 32'hD0, 1'b0, 1'b1);
        tick();
        check("fl_two_in_ready", {31'd0, in_ready}, 32'd0);
        check("fl_two_dram_we", {31'd0, dram_we_o}, 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 5'd12, 32'hE0, 1'b1, 1'b1);
        tick();
`else
        check("bp_in_ready_comb_low", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_hold_wR", {27'd0, wR_o}, 32'd7);
        check("bp_hold_alu", alu_c_o, 32'hA0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb_high", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_both_fire_wR", {27'd0, wR_o}, 32'd8);
        check("bp_both_fire_valid", {31'd0, out_valid}, 32'd1);
        check("fl_full_dram_we", {31'd0, dram_we_o}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 5'd12, 32'hE0, 1'b1, 1'b1);
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_dram_we", {31'd0, dram_we_o}, 32'd0);
        check("fl_rf_we", {31'd0, rf_we_o}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("fl_input_lost", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset asserted mid-stream drops the held entry.
        out_ready = 1'b0;
        drive(1'b1, 5'd13, 32'hF0, 1'b1, 1'b0);
        tick();
        check("mr_loaded", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_alu", alu_c_o, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mr_in_ready_rel", {31'd0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
